// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 7;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (distributed) read.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk_in,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are intentionally left unreset.
    always_ff @(posedge clk_in) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERRFLAGS_EN is defined;
// otherwise those ports are tied low.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               wr_en,
    output logic                               full,
    output logic [WIDTH-1:0]                   dout,
    input  logic                               rd_en,
    output logic                               empty,
    output logic [count_width(DEPTH_LOG2)-1:0] data_count,
    output logic                               overflow_out,
    output logic                               underflow_out
);

    localparam int unsigned CW = count_width(DEPTH_LOG2);
    localparam logic [CW-1:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_we;
    logic                  w_re;
    logic [CW-1:0]         w_count_d;

    // Strobes are qualified by the registered flags, so a full FIFO prefers the read
    // and an empty FIFO prefers the write.
    assign w_we = wr_en & ~r_full;
    assign w_re = rd_en & ~r_empty;

    // Next occupancy from the qualified strobes.
    always_comb begin
        w_count_d = r_count;
        case ({w_we, w_re})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Pointers, count and flags; flags derive from the next count so they track data_count.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_we) begin
                r_wp <= r_wp + DEPTH_LOG2'(1);
            end
            if (w_re) begin
                r_rp <= r_rp + DEPTH_LOG2'(1);
            end
            r_count <= w_count_d;
            r_full  <= (w_count_d == FULL_COUNT);
            r_empty <= (w_count_d == '0);
        end
    end

    sync_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_in  (clk_in),
        .i_we    (w_we),
        .i_waddr (r_wp),
        .i_wdata (din),
        .i_raddr (r_rp),
        .o_rdata (dout)
    );

    assign full       = r_full;
    assign empty      = r_empty;
    assign data_count = r_count;

`ifdef SYNC_FIFO_ERRFLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_out  = r_overflow;
    assign underflow_out = r_underflow;
`else
    assign overflow_out  = 1'b0;
    assign underflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DL2   = 7;
    localparam int unsigned DEPTH = 1 << DL2;

    logic             clk_in;
    logic             reset_in;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             rd_en;
    logic             empty;
    logic [DL2:0]     data_count;
    logic             overflow_out;
    logic             underflow_out;

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .din           (din),
        .wr_en         (wr_en),
        .full          (full),
        .dout          (dout),
        .rd_en         (rd_en),
        .empty         (empty),
        .data_count    (data_count),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Reference model state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_udf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 32'(data_count), 32'(m_q.size()));
        check_eq({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
        check_eq({tag, ".ovf"}, 32'(overflow_out), 32'(m_ovf));
        check_eq({tag, ".udf"}, 32'(underflow_out), 32'(m_udf));
        if (m_q.size() != 0) begin
            check_eq({tag, ".head"}, 32'(dout), 32'(m_q[0]));
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d, input string tag);
        bit was_full;
        bit was_empty;
        wr_en = w;
        rd_en = r;
        din   = d;
        #1;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        // Head must be presented in the same cycle as the pop.
        if (r && !was_empty) begin
            check_eq({tag, ".pop"}, 32'(dout), 32'(m_q[0]));
        end
`ifdef SYNC_FIFO_ERRFLAGS_EN
        if (w && was_full)  m_ovf = 1'b1;
        if (r && was_empty) m_udf = 1'b1;
`endif
        if (r && !was_empty) void'(m_q.pop_front());
        if (w && !was_full)  m_q.push_back(d);
        @(posedge clk_in);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    // Async reset asserted mid-cycle; state must clear before any clock edge.
    task automatic mid_reset(input string tag);
        #2;
        reset_in = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state(tag);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_state("reset");
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_state("post_reset");

        // Pop from empty: count stays 0, underflow follows the build option.
        cycle(1'b0, 1'b1, 8'h00, "pop_empty");

        // Short in-order burst.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 8'(i), "wr5");
        check_eq("count5", 32'(data_count), 32'd5);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'h00, "rd5");
        check_eq("empty5", 32'(empty), 32'd1);

        // Fill, overfill, full with both strobes, drain.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), "fill");
        check_eq("full128", 32'(full), 32'd1);
        check_eq("count128", 32'(data_count), 32'd128);
        cycle(1'b1, 1'b0, 8'hAA, "overfill");
        cycle(1'b1, 1'b1, 8'hBB, "full_both");
        check_eq("count127", 32'(data_count), 32'd127);
        while (m_q.size() != 0) cycle(1'b0, 1'b1, 8'h00, "drain");

        // Empty with both strobes: write wins.
        cycle(1'b1, 1'b1, 8'h3C, "empty_both");
        check_eq("count1", 32'(data_count), 32'd1);
        check_eq("head3c", 32'(dout), 32'h3C);
        cycle(1'b0, 1'b1, 8'h00, "pop3c");

        // Steady state at 64 with simultaneous strobes.
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 8'($urandom), "fill64");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'($urandom), "both64");
        check_eq("count64", 32'(data_count), 32'd64);

        // Random mixed traffic; pointers wrap many times.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
        end

        // Mid-cycle reset with 37 items stored.
        while (m_q.size() > 37) cycle(1'b0, 1'b1, 8'h00, "trim");
        while (m_q.size() < 37) cycle(1'b1, 1'b0, 8'($urandom), "grow");
        mid_reset("mid_reset");
        cycle(1'b1, 1'b0, 8'h5C, "wr5c");
        check_eq("read5c", 32'(dout), 32'h5C);
        cycle(1'b0, 1'b1, 8'h00, "pop5c");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

First-word-fall-through synchronous FIFO with occupancy count, buffering bytes between a producer (timer-paced counter or host channel write path) and a consumer (host channel read path or LED drain). Its head item is presented combinationally so that comm_fpga can sample `dout` in the same cycle it asserts `chanRead`. Occupancy feeds the channel-1/2 depth registers and the seven-segment display.

## Interface

- `WIDTH`, 8, data width in bits.
- `DEPTH_LOG2`, 7, log2 of storage depth (128 entries).

- `clk_in`  in  1  single clock (fx2Clk_in domain).
- `reset_in`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  write data.
- `wr_en`  in  1  write strobe; ignored while `full`.
- `full`  out  1  high when count == 2^DEPTH_LOG2.
- `dout`  out  WIDTH  head item; valid whenever `empty` is low.
- `rd_en`  in  1  pop strobe; ignored while `empty`.
- `empty`  out  1  high when count == 0.
- `data_count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `overflow_out`  out  1  sticky write-while-full flag (see Configuration).
- `underflow_out`  out  1  sticky read-while-empty flag (see Configuration).

## Operation

- Storage: 2^DEPTH_LOG2 entries; write pointer `wp`, read pointer `rp`, each DEPTH_LOG2 bits, wrapping modulo depth; separate count register, DEPTH_LOG2+1 bits.
- Effective write `we = wr_en & ~full`; effective read `re = rd_en & ~empty`.
- On `we`: `mem[wp] <= din`, `wp <= wp+1`.
- On `re`: `rp <= rp+1`.
- Count: +1 on `we & ~re`; -1 on `re & ~we`; unchanged on both or neither.
- `full`/`empty` are registered and derived from the next count, so they match `data_count` every cycle.
- `dout = mem[rp]`, read asynchronously. `dout` is don't-care while `empty`.
- Simultaneous `wr_en` and `rd_en` when full: read accepted, write dropped (no pass-through).
- Simultaneous `wr_en` and `rd_en` when empty: write accepted, read dropped. `empty` deasserts next cycle.
- Reset (async assert, sync release): `wp = rp = 0`, `data_count = 0`, `empty = 1`, `full = 0`, `overflow_out = 0`, `underflow_out = 0`. Memory contents are not reset.
- Reset asserted mid-burst discards all stored items immediately. The first strobe after reset release is handled normally.

## Timing

- Write latency: `wr_en` sampled at edge N. The item is visible on `dout`, `empty` drops and `data_count` increments after edge N.
- Read: `dout` is valid in the same cycle `rd_en` is asserted. `rd_en` at edge N advances to the next item after edge N.
- `full`, `empty` and `data_count` all change only on `clk_in` rising edges, or asynchronously on reset assertion.
- No combinational path from `wr_en`/`rd_en` to any output. `dout` depends combinationally only on `rp` and memory.

## Configuration

- `SYNC_FIFO_ERRFLAGS_EN` defined:
  - `overflow_out` sets on `wr_en & full`.
  - `underflow_out` sets on `rd_en & empty`.
  - Both hold until `reset_in`.
- Macro undefined: both ports are tied to 0 and no error registers are built. Ports remain present so instantiations are unchanged.

## Structure

- Shared package `sync_fifo_pkg`: default `WIDTH`/`DEPTH_LOG2` constants and the count-width function (DEPTH_LOG2+1).
- Sub-module `sync_fifo_ram`: simple dual-port RAM with synchronous write and asynchronous read (distributed RAM). All pointer, count, flag and error logic stays in `sync_fifo`.

## Test plan

- Reset, then write 0x01..0x05 on consecutive cycles, then pop 5 -> `dout` reads 0x01..0x05 in order; `data_count` goes 0→5→0; `empty` = 1 at the end.
- Fill 128 items (0x00..0x7F) -> `full` = 1 and `data_count` = 128. A 129th write of 0xAA is dropped; drain reads 0x00..0x7F only. With the macro defined, `overflow_out` = 1.
- Pop from empty after reset -> `data_count` stays 0 and `dout` is ignored. With the macro, `underflow_out` = 1; without it, `underflow_out` = 0.
- Hold count at 64, assert `wr_en` and `rd_en` together for 10 cycles -> `data_count` stays 64; pointers wrap past 127→0 without corruption across 300 mixed operations versus a scoreboard.
- Full with simultaneous `wr_en`/`rd_en` -> count 127 and the write is dropped. Empty with simultaneous strobes -> count 1 and `dout` = written value next cycle.
- Assert `reset_in` mid-cycle with 37 items stored -> `empty` = 1 and `data_count` = 0 immediately, without waiting for a clock edge. Error flags clear. A subsequent write of 0x5C is read back as 0x5C.
